// File: rtl/runtime_config_regs.sv
// runtime_config_regs
//   Runtime configuration register bank for the effects application core.
//   A control master writes the shadow set (enable mask, noisegate threshold,
//   chorus timing/depth, control-input assignment map). A commit arms a transfer.
//   On the next audio sample strobe the shadow set is validated and then either
//   copied to the active set in one cycle or rejected. The core therefore never
//   sees a half-updated set. Raw control inputs are remapped through the active map.
//
// Ports
//   clk_i, srst_n_i          clock, synchronous active-low reset
//   wr_valid_i/wr_ready_o    write handshake (ready low while a commit is armed)
//   wr_addr_i, wr_data_i     write address/data (fields LSB-aligned)
//   wr_err_o                 pulse: previous accepted write hit an illegal address
//   commit_i, sample_tick_i  commit request, audio sample strobe
//   commit_pending_o         commit armed, waiting for the strobe
//   commit_done_o/_err_o     pulse: active set updated / commit rejected
//   rd_addr_i, rd_data_o     active-set readback, 1-cycle latency
//   knobs_i, knobs_o         raw inputs in, remapped outputs (logical i = physical map[i])
//   en_o, ng_thr_o, cho_max_o, cho_min_o, cho_depth_o   active values
module runtime_config_regs #(
  parameter int unsigned NUM_EFFECTS       = 8,
  parameter int unsigned NUM_KNOBS         = 8,
  parameter int unsigned KNOB_WIDTH        = 8,
  parameter int unsigned REG_WIDTH         = 16,
  parameter int unsigned EN_DEFAULT        = 'h62,
  parameter int unsigned NG_THR_DEFAULT    = 300,
  parameter int unsigned CHO_MAX_DEFAULT   = 'h530,
  parameter int unsigned CHO_MIN_DEFAULT   = 'h370,
  parameter int unsigned CHO_DEPTH_DEFAULT = 'h80,
  localparam int unsigned AW = $clog2(5 + NUM_KNOBS),
  localparam int unsigned MW = $clog2(NUM_KNOBS)
) (
  input  logic                             clk_i,
  input  logic                             srst_n_i,
  input  logic                             wr_valid_i,
  output logic                             wr_ready_o,
  input  logic [AW-1:0]                    wr_addr_i,
  input  logic [REG_WIDTH-1:0]             wr_data_i,
  output logic                             wr_err_o,
  input  logic                             commit_i,
  input  logic                             sample_tick_i,
  output logic                             commit_pending_o,
  output logic                             commit_done_o,
  output logic                             commit_err_o,
  input  logic [AW-1:0]                    rd_addr_i,
  output logic [REG_WIDTH-1:0]             rd_data_o,
  input  logic [NUM_KNOBS*KNOB_WIDTH-1:0]  knobs_i,
  output logic [NUM_KNOBS*KNOB_WIDTH-1:0]  knobs_o,
  output logic [NUM_EFFECTS-1:0]           en_o,
  output logic [REG_WIDTH-1:0]             ng_thr_o,
  output logic [REG_WIDTH-1:0]             cho_max_o,
  output logic [REG_WIDTH-1:0]             cho_min_o,
  output logic [7:0]                       cho_depth_o
);

  localparam int unsigned NUM_REGS = 5 + NUM_KNOBS;

  typedef enum logic {IDLE, PENDING} state_t;
  typedef logic [NUM_KNOBS-1:0][MW-1:0] map_t;
  typedef logic [NUM_KNOBS-1:0][KNOB_WIDTH-1:0] knob_arr_t;

  state_t state_q, state_d;

  logic [NUM_EFFECTS-1:0] shd_en, act_en;
  logic [REG_WIDTH-1:0]   shd_ng, act_ng, shd_max, act_max, shd_min, act_min;
  logic [7:0]             shd_depth, act_depth;
  map_t                   shd_map, act_map;

  logic                   wr_fire, wr_legal, apply_tick, commit_ok;
  logic [REG_WIDTH-1:0]   rd_next;
  knob_arr_t              knobs_raw, knobs_map;

  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < int'(NUM_KNOBS); i++) m[i] = MW'(i);
    return m;
  endfunction

  // Commit is legal only if the chorus window is ordered and every physical
  // input index is used exactly once (a duplicate necessarily leaves one index unseen).
  function automatic logic shadow_ok(input logic [REG_WIDTH-1:0] mn,
                                     input logic [REG_WIDTH-1:0] mx,
                                     input map_t m);
    logic [NUM_KNOBS-1:0] seen;
    seen = '0;
    for (int i = 0; i < int'(NUM_KNOBS); i++)
      if (32'(m[i]) < NUM_KNOBS) seen[m[i]] = 1'b1;
    return (mn <= mx) && (&seen);
  endfunction

  assign wr_fire    = wr_valid_i && wr_ready_o;
  assign wr_legal   = 32'(wr_addr_i) < NUM_REGS;
  assign apply_tick = (state_q == PENDING) && sample_tick_i;
  assign commit_ok  = shadow_ok(shd_min, shd_max, shd_map);

  // Commit FSM: next state and handshake outputs
  always_comb begin
    state_d          = state_q;
    wr_ready_o       = 1'b0;
    commit_pending_o = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready_o = 1'b1;
        if (commit_i) state_d = PENDING;
      end
      PENDING: begin
        commit_pending_o = 1'b1;
        if (sample_tick_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Shadow set: written only while the handshake is open
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      shd_en    <= NUM_EFFECTS'(EN_DEFAULT);
      shd_ng    <= REG_WIDTH'(NG_THR_DEFAULT);
      shd_max   <= REG_WIDTH'(CHO_MAX_DEFAULT);
      shd_min   <= REG_WIDTH'(CHO_MIN_DEFAULT);
      shd_depth <= 8'(CHO_DEPTH_DEFAULT);
      shd_map   <= identity_map();
    end else if (wr_fire) begin
      case (32'(wr_addr_i))
        0: shd_en    <= wr_data_i[NUM_EFFECTS-1:0];
        1: shd_ng    <= wr_data_i;
        2: shd_max   <= wr_data_i;
        3: shd_min   <= wr_data_i;
        4: shd_depth <= wr_data_i[7:0];
        default: begin
          for (int i = 0; i < int'(NUM_KNOBS); i++)
            if (32'(wr_addr_i) == 32'(5 + i)) shd_map[i] <= wr_data_i[MW-1:0];
        end
      endcase
    end
  end

  // Active set: whole-set copy on a validated strobe
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      act_en    <= NUM_EFFECTS'(EN_DEFAULT);
      act_ng    <= REG_WIDTH'(NG_THR_DEFAULT);
      act_max   <= REG_WIDTH'(CHO_MAX_DEFAULT);
      act_min   <= REG_WIDTH'(CHO_MIN_DEFAULT);
      act_depth <= 8'(CHO_DEPTH_DEFAULT);
      act_map   <= identity_map();
    end else if (apply_tick && commit_ok) begin
      act_en    <= shd_en;
      act_ng    <= shd_ng;
      act_max   <= shd_max;
      act_min   <= shd_min;
      act_depth <= shd_depth;
      act_map   <= shd_map;
    end
  end

  always_comb begin
    rd_next = '0;
    case (32'(rd_addr_i))
      0: rd_next = REG_WIDTH'(act_en);
      1: rd_next = act_ng;
      2: rd_next = act_max;
      3: rd_next = act_min;
      4: rd_next = REG_WIDTH'(act_depth);
      default: begin
        for (int i = 0; i < int'(NUM_KNOBS); i++)
          if (32'(rd_addr_i) == 32'(5 + i)) rd_next = REG_WIDTH'(act_map[i]);
      end
    endcase
  end

  assign knobs_raw = knobs_i;
  always_comb begin
    for (int i = 0; i < int'(NUM_KNOBS); i++) knobs_map[i] = knobs_raw[act_map[i]];
  end

  // Output stage: pulses, readback and remapped inputs
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      wr_err_o      <= 1'b0;
      commit_done_o <= 1'b0;
      commit_err_o  <= 1'b0;
      rd_data_o     <= '0;
      knobs_o       <= '0;
    end else begin
      wr_err_o      <= wr_fire && !wr_legal;
      commit_done_o <= apply_tick && commit_ok;
      commit_err_o  <= apply_tick && !commit_ok;
      rd_data_o     <= rd_next;
      knobs_o       <= knobs_map;
    end
  end

  assign en_o        = act_en;
  assign ng_thr_o    = act_ng;
  assign cho_max_o   = act_max;
  assign cho_min_o   = act_min;
  assign cho_depth_o = act_depth;

endmodule

// File: tb/tb_runtime_config_regs.sv
module tb_runtime_config_regs;

  logic        clk = 1'b0;
  logic        srst_n_i = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [3:0]  wr_addr_i = '0;
  logic [15:0] wr_data_i = '0;
  logic        wr_err_o;
  logic        commit_i = 1'b0;
  logic        sample_tick_i = 1'b0;
  logic        commit_pending_o, commit_done_o, commit_err_o;
  logic [3:0]  rd_addr_i = '0;
  logic [15:0] rd_data_o;
  logic [63:0] knobs_i = '0;
  logic [63:0] knobs_o;
  logic [7:0]  en_o;
  logic [15:0] ng_thr_o, cho_max_o, cho_min_o;
  logic [7:0]  cho_depth_o;

  always #5 clk = ~clk;

  runtime_config_regs dut (
    .clk_i(clk), .srst_n_i(srst_n_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_err_o(wr_err_o),
    .commit_i(commit_i), .sample_tick_i(sample_tick_i),
    .commit_pending_o(commit_pending_o), .commit_done_o(commit_done_o),
    .commit_err_o(commit_err_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .knobs_i(knobs_i), .knobs_o(knobs_o),
    .en_o(en_o), .ng_thr_o(ng_thr_o), .cho_max_o(cho_max_o),
    .cho_min_o(cho_min_o), .cho_depth_o(cho_depth_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: register file indexed by address
  int sh[13];
  int act[13];
  bit pend;
  const int DEFS[5] = '{'h62, 300, 'h530, 'h370, 'h80};

  function automatic int field_mask(input int a);
    if (a == 0 || a == 4) return 'hFF;
    if (a <= 3) return 'hFFFF;
    return 'h7;
  endfunction

  function automatic bit model_valid();
    int cnt[8];
    if (sh[3] > sh[2]) return 1'b0;
    foreach (cnt[j]) cnt[j] = 0;
    for (int i = 0; i < 8; i++) cnt[sh[5+i]]++;
    foreach (cnt[j]) if (cnt[j] != 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 13; i++) begin
      sh[i]  = (i < 5) ? DEFS[i] : i - 5;
      act[i] = sh[i];
    end
    pend = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp_v);
    end
  endtask

  task automatic step(input logic wv, input logic [3:0] a, input logic [15:0] d,
                      input logic c, input logic t, input logic [3:0] ra,
                      input logic [63:0] k);
    int nsh[13];
    int nact[13];
    bit npend, edone, eerr, ewerr, acc;
    logic [15:0] erd;
    logic [63:0] ek;
    wr_valid_i = wv; wr_addr_i = a; wr_data_i = d;
    commit_i = c; sample_tick_i = t; rd_addr_i = ra; knobs_i = k;
    acc   = wv && !pend;
    ewerr = acc && (a >= 13);
    erd   = (ra < 13) ? 16'(act[ra]) : 16'h0;
    for (int i = 0; i < 8; i++) ek[i*8 +: 8] = k[act[5+i]*8 +: 8];
    nsh = sh; nact = act; npend = pend; edone = 1'b0; eerr = 1'b0;
    if (pend && t) begin
      if (model_valid()) begin nact = sh; edone = 1'b1; end
      else eerr = 1'b1;
      npend = 1'b0;
    end else if (!pend && c) begin
      npend = 1'b1;
    end
    if (acc && a < 13) nsh[a] = int'(d) & field_mask(int'(a));
    @(posedge clk);
    #1;
    chk("wr_ready", 64'(wr_ready_o), 64'(!npend));
    chk("pending", 64'(commit_pending_o), 64'(npend));
    chk("done", 64'(commit_done_o), 64'(edone));
    chk("cerr", 64'(commit_err_o), 64'(eerr));
    chk("wr_err", 64'(wr_err_o), 64'(ewerr));
    chk("rd_data", 64'(rd_data_o), 64'(erd));
    chk("knobs", knobs_o, ek);
    chk("en", 64'(en_o), 64'(nact[0]));
    chk("ng_thr", 64'(ng_thr_o), 64'(nact[1]));
    chk("cho_max", 64'(cho_max_o), 64'(nact[2]));
    chk("cho_min", 64'(cho_min_o), 64'(nact[3]));
    chk("cho_depth", 64'(cho_depth_o), 64'(nact[4]));
    sh = nsh; act = nact; pend = npend;
  endtask

  task automatic reset_dut(input logic t);
    srst_n_i = 1'b0; wr_valid_i = 1'b0; commit_i = 1'b0; sample_tick_i = t;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_ready", 64'(wr_ready_o), 64'd1);
    chk("rst_pending", 64'(commit_pending_o), 64'd0);
    chk("rst_pulses", 64'({wr_err_o, commit_done_o, commit_err_o}), 64'd0);
    chk("rst_rd", 64'(rd_data_o), 64'd0);
    chk("rst_knobs", knobs_o, 64'd0);
    chk("rst_en", 64'(en_o), 64'h62);
    chk("rst_cho_max", 64'(cho_max_o), 64'h530);
    srst_n_i = 1'b1; sample_tick_i = 1'b0;
  endtask

  typedef struct {
    logic        wv;
    logic [3:0]  a;
    logic [15:0] d;
    logic        c, t;
    logic [3:0]  ra;
    logic [15:0] e_rd;
    logic        e_ready, e_pend, e_done, e_err, e_werr;
  } vec_t;

  vec_t tbl[25];
  int   p[8];

  initial begin
    // wv a d c t ra | rd ready pend done err werr
    tbl[0]  = '{0, 0, 16'h0,    0, 0, 0,  16'h62,  1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 16'h0,    0, 0, 1,  16'd300, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 16'h0,    0, 0, 2,  16'h530, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 16'h0,    0, 0, 3,  16'h370, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 16'h0,    0, 0, 4,  16'h80,  1, 0, 0, 0, 0};
    tbl[5]  = '{1, 2, 16'h600,  0, 0, 2,  16'h530, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 16'h0,    1, 0, 2,  16'h530, 0, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 16'h0,    0, 0, 2,  16'h530, 0, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 16'h0,    0, 1, 2,  16'h530, 1, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 16'h0,    0, 0, 2,  16'h600, 1, 0, 0, 0, 0};
    tbl[10] = '{1, 3, 16'h700,  1, 0, 3,  16'h370, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 16'h0,    0, 1, 3,  16'h370, 1, 0, 0, 1, 0};
    tbl[12] = '{1, 3, 16'h370,  0, 0, 3,  16'h370, 1, 0, 0, 0, 0};
    tbl[13] = '{1, 13, 16'hFFFF, 0, 0, 0, 16'h62,  1, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 16'h0,    0, 0, 13, 16'h0,   1, 0, 0, 0, 0};
    tbl[15] = '{1, 5, 16'h7,    0, 0, 5,  16'h0,   1, 0, 0, 0, 0};
    tbl[16] = '{1, 12, 16'h0,   0, 0, 12, 16'h7,   1, 0, 0, 0, 0};
    tbl[17] = '{0, 0, 16'h0,    1, 1, 5,  16'h0,   0, 1, 0, 0, 0};
    tbl[18] = '{1, 0, 16'hFF,   0, 0, 5,  16'h0,   0, 1, 0, 0, 0};
    tbl[19] = '{1, 0, 16'hFF,   0, 1, 5,  16'h0,   1, 0, 1, 0, 0};
    tbl[20] = '{1, 0, 16'hFF,   0, 0, 5,  16'h7,   1, 0, 0, 0, 0};
    tbl[21] = '{0, 0, 16'h0,    0, 0, 0,  16'h62,  1, 0, 0, 0, 0};
    tbl[22] = '{1, 6, 16'h7,    1, 0, 6,  16'h1,   0, 1, 0, 0, 0};
    tbl[23] = '{0, 0, 16'h0,    0, 1, 0,  16'h62,  1, 0, 0, 1, 0};
    tbl[24] = '{0, 0, 16'h0,    0, 0, 12, 16'h0,   1, 0, 0, 0, 0};

    reset_dut(1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].wv, tbl[i].a, tbl[i].d, tbl[i].c, tbl[i].t, tbl[i].ra,
           64'h7766554433221100);
      chk($sformatf("vec%0d_rd", i), 64'(rd_data_o), 64'(tbl[i].e_rd));
      chk($sformatf("vec%0d_ready", i), 64'(wr_ready_o), 64'(tbl[i].e_ready));
      chk($sformatf("vec%0d_pend", i), 64'(commit_pending_o), 64'(tbl[i].e_pend));
      chk($sformatf("vec%0d_done", i), 64'(commit_done_o), 64'(tbl[i].e_done));
      chk($sformatf("vec%0d_cerr", i), 64'(commit_err_o), 64'(tbl[i].e_err));
      chk($sformatf("vec%0d_werr", i), 64'(wr_err_o), 64'(tbl[i].e_werr));
    end
    // Swapped map still active: logical 0 <- physical 7, logical 7 <- physical 0
    chk("swap_k0", 64'(knobs_o[7:0]), 64'h77);
    chk("swap_k7", 64'(knobs_o[63:56]), 64'h00);
    chk("en_uncommitted", 64'(en_o), 64'h62);

    // Reset while a commit is armed drops it and restores defaults
    step(1'b1, 4'd2, 16'h100, 1'b1, 1'b0, 4'd0, 64'h0123456789ABCDEF);
    chk("mid_pend_armed", 64'(commit_pending_o), 64'd1);
    reset_dut(1'b1);
    step(1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 4'd2, 64'h0123456789ABCDEF);
    chk("mid_pend_rd", 64'(rd_data_o), 64'h530);
    chk("mid_pend_done", 64'(commit_done_o), 64'd0);
    step(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd5, 64'h0123456789ABCDEF);
    chk("mid_pend_map", 64'(rd_data_o), 64'd0);
    chk("mid_pend_knobs", knobs_o, 64'h0123456789ABCDEF);

    // Randomized traffic against the model
    for (int b = 0; b < 40; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 8; j++) p[j] = j;
        for (int j = 7; j > 0; j--) begin
          int r, tmp;
          r = int'($urandom_range(0, j));
          tmp = p[j]; p[j] = p[r]; p[r] = tmp;
        end
        for (int j = 0; j < 8; j++)
          step(1'b1, 4'(5 + j), 16'(($urandom_range(0, 8191) << 3) | p[j]),
               1'b0, 1'b0, 4'($urandom_range(0, 15)), {$urandom, $urandom});
      end
      for (int n = 0; n < 20; n++) begin
        logic [3:0]  ra, wa;
        logic [15:0] wd;
        wa = 4'($urandom_range(0, 15));
        ra = 4'($urandom_range(0, 15));
        wd = (wa == 2 || wa == 3) ? 16'($urandom_range(0, 'hFFF)) : 16'($urandom);
        step(1'($urandom_range(0, 1)), wa, wd,
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
             ra, {$urandom, $urandom});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
